// File: rtl/led7seg_scan_if.sv
// Display-side bundle for led7seg_scan: load strobe with packed digits in, scanned pins out.
interface led7seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, blank_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/led7seg_scan.sv
// Time-multiplexed multi-digit hex 7-segment driver with tear-free frame commit.
// Optional leading-zero suppression is enabled by defining LED7SEG_LZS_EN.
module led7seg_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIV            = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  led7seg_scan_if.slave bus
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    tick, wrap;

  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;

  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              digit_sel;
  logic                    dp_sel, dark;
  logic [NUM_DIGITS-1:0]   an_hot;

  logic                    wrap_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Prescaler and digit index
  always_comb begin
    tick  = (cnt_q == CntMax);
    wrap  = tick && (idx_q == IdxMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Loads park in the pending bank; the display bank only changes on the wrap edge,
  // so every frame shows a single consistent value.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (wrap) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        disp_val_d   = bus.value;
        disp_dp_d    = bus.dp_in;
        disp_blank_d = bus.blank_in;
      end else if (pend_valid_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
    end else if (bus.load) begin
      pend_valid_d = 1'b1;
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank_in;
    end
  end

`ifdef LED7SEG_LZS_EN
  logic lead_zero;

  // Walk down from the top digit; stays suppressed until the first nonzero digit.
  always_comb begin
    suppress  = '0;
    lead_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (disp_val_q[4*k +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      suppress[k] = lead_zero;
    end
  end
`else
  assign suppress = '0;
`endif

  // Output stage, polarity applied last
  always_comb begin
    digit_sel = '0;
    dp_sel    = 1'b0;
    dark      = 1'b0;
    an_hot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        digit_sel = disp_val_q[4*k +: 4];
        dp_sel    = disp_dp_q[k];
        dark      = disp_blank_q[k] | suppress[k];
        an_hot[k] = 1'b1;
      end
    end
    seg_d = (dark ? 7'h00 : hex_to_seg(digit_sel)) ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = (dp_sel & ~dark) ^ SEG_ACTIVE_LOW;
    an_d  = (dark ? '0 : an_hot) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      wrap_q       <= 1'b0;
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_q         <= SEG_ACTIVE_LOW;
      an_q         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      wrap_q       <= wrap;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      // Lines up with the first registered output cycle of digit 0
      frame_done_q <= wrap_q;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan (4 digits, DIV=4, active-low pins): table vectors, corner sequences,
// and random loads checked against a time-arithmetic reference model.
module tb_led7seg_scan;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  blank;
    logic [27:0] seg4;    // expected pin levels, digit d at [7d +: 7]
    logic [3:0]  dp_pin;  // expected dp pin level per digit
    logic [3:0]  an_on;   // digit enabled in this frame
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  led7seg_scan_if #(.NUM_DIGITS(N)) bus ();

  led7seg_scan #(
    .NUM_DIGITS    (N),
    .DIV           (DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  dec_tab [16];
  int          k;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_blank, p_dp, p_blank;
  bit          p_valid;
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at k=%0d", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_val   = '0;
    m_dp    = '0;
    m_blank = 4'hF;
    p_valid = 1'b0;
    p_val   = '0;
    p_dp    = '0;
    p_blank = '0;
  endtask

  // Expected pins after the next edge, from the state after k edges.
  function automatic void exp_out(output logic [6:0] s, output logic d, output logic [3:0] a,
                                  output logic fd);
    int idx;
    bit off;
`ifdef LED7SEG_LZS_EN
    int msd;
`endif
    idx = (k / DIV) % N;
`ifdef LED7SEG_LZS_EN
    msd = 0;
    for (int i = 0; i < N; i++) if (m_val[4*i +: 4] != 4'h0) msd = i;
    off = m_blank[idx] || (idx > msd);
`else
    off = m_blank[idx];
`endif
    if (off) begin
      s = 7'h7F;
      d = 1'b1;
      a = 4'hF;
    end else begin
      s = dec_tab[m_val[4*idx +: 4]] ^ 7'h7F;
      d = ~m_dp[idx];
      a = ~(4'b0001 << idx);
    end
    fd = (k > 0) && (k % FRAME == 0);
  endfunction

  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] b);
    logic [6:0] es;
    logic       ed, ef;
    logic [3:0] ea;
    int         e;
    bus.load     = ld;
    bus.value    = v;
    bus.dp_in    = d;
    bus.blank_in = b;
    exp_out(es, ed, ea, ef);
    @(posedge clk);
    e = k + 1;
    if (e % FRAME == 0) begin
      if (ld) begin
        m_val = v; m_dp = d; m_blank = b;
      end else if (p_valid) begin
        m_val = p_val; m_dp = p_dp; m_blank = p_blank;
      end
      p_valid = 1'b0;
    end else if (ld) begin
      p_val = v; p_dp = d; p_blank = b; p_valid = 1'b1;
    end
    k = e;
    @(negedge clk);
    bus.load = 1'b0;
    chk("model_seg", 32'(bus.seg), 32'(es));
    chk("model_dp", 32'(bus.dp), 32'(ed));
    chk("model_an", 32'(bus.an), 32'(ea));
    chk("model_frame_done", 32'(bus.frame_done), 32'(ef));
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpv,
                              input logic [3:0] blank, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dp_pin, input logic [3:0] an_on);
    vec_t r;
    r.val    = val;
    r.dpv    = dpv;
    r.blank  = blank;
    r.seg4   = {s3, s2, s1, s0};
    r.dp_pin = dp_pin;
    r.an_on  = an_on;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    bit         seen;
    int         d;
    logic [3:0] ea;
    cycle(1'b1, v.val, v.dpv, v.blank);
    seen = (k % FRAME == 0);
    while (!(seen && (k % FRAME == 1))) begin
      idle();
      if (k % FRAME == 0) seen = 1'b1;
    end
    for (int j = 0; j < FRAME; j++) begin
      d  = j / DIV;
      ea = v.an_on[d] ? ~(4'b0001 << d) : 4'hF;
      chk($sformatf("vec%0d_seg_d%0d", id, d), 32'(bus.seg), 32'(v.seg4[7*d +: 7]));
      chk($sformatf("vec%0d_dp_d%0d", id, d), 32'(bus.dp), 32'(v.dp_pin[d]));
      chk($sformatf("vec%0d_an_d%0d", id, d), 32'(bus.an), 32'(ea));
      if (j < FRAME - 1) idle();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = mk(16'h12AF, 4'b0100, 4'b0000, 7'h79, 7'h24, 7'h08, 7'h0E, 4'b1011, 4'b1111);
    vecs[1] = mk(16'h8888, 4'b0000, 4'b1010, 7'h7F, 7'h00, 7'h7F, 7'h00, 4'b1111, 4'b0101);
`ifdef LED7SEG_LZS_EN
    vecs[2] = mk(16'h0050, 4'b1111, 4'b0000, 7'h7F, 7'h7F, 7'h12, 7'h40, 4'b1100, 4'b0011);
    vecs[3] = mk(16'h0000, 4'b0000, 4'b0000, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 4'b0001);
`else
    vecs[2] = mk(16'h0050, 4'b1111, 4'b0000, 7'h40, 7'h40, 7'h12, 7'h40, 4'b0000, 4'b1111);
    vecs[3] = mk(16'h0000, 4'b0000, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4'b1111);
`endif
    vecs[4] = mk(16'hBCDE, 4'b0001, 4'b0000, 7'h03, 7'h46, 7'h21, 7'h06, 4'b1110, 4'b1111);
    vecs[5] = mk(16'h9476, 4'b0000, 4'b0001, 7'h10, 7'h19, 7'h78, 7'h7F, 4'b1111, 4'b1110);

    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Tear-free: two loads inside one frame, only the last one appears next frame
    while (k % FRAME != 8) idle();
    cycle(1'b1, 16'h1111, 4'h0, 4'h0);
    idle();
    idle();
    cycle(1'b1, 16'h2222, 4'h0, 4'h0);
    while (k % FRAME != 1) idle();
    for (int j = 0; j < FRAME; j++) begin
      chk("tearfree_seg", 32'(bus.seg), 32'h24);
      if (j < FRAME - 1) idle();
    end

    // Load on the wrap edge commits directly
    while (k % FRAME != FRAME - 1) idle();
    cycle(1'b1, 16'h3333, 4'h0, 4'h0);
    chk("wrap_load_pend_valid", 32'(dut.pend_valid_q), 32'h0);
    idle();
    chk("wrap_load_seg_d0", 32'(bus.seg), 32'h30);
    chk("wrap_load_an_d0", 32'(bus.an), 32'hE);

    // Reset mid-frame with a load pending
    while (k % FRAME != 5) idle();
    cycle(1'b1, 16'h4444, 4'h0, 4'h0);
    idle();
    do_reset();
    for (int j = 0; j < 2 * FRAME; j++) idle();

    // Random loads against the model, with one reset in the middle
    for (int j = 0; j < 800; j++) begin
      if (j == 400) do_reset();
      if ($urandom_range(0, 7) == 0) begin
        cycle(1'b1, 16'($urandom), 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end else begin
        idle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led7seg_scan.md
# led7seg_scan

Parametrised, time-multiplexed hex driver for common-anode/common-cathode multi-digit 7-segment displays. Accepts an N-digit packed hex value via a load strobe, holds it tear-free in shadow registers, and scans one digit at a time with a programmable refresh prescaler. Sits between the board I/O pins and any counter/datapath producing display values; replaces per-digit combinational decoders.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1..8).
- DIV, 50000: clock cycles each digit stays on (>= 1).
- SEG_ACTIVE_LOW, 1: 1 = segment/dp pins driven low to light.
- AN_ACTIVE_LOW, 1: 1 = anode/select pins driven low to enable.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures value/dp_in/blank_in.
- value  in  4*NUM_DIGITS  packed hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit k fully dark (segments, dp, anode off).
- seg  out  7  segments, seg[0]=a .. seg[6]=g, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
- an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when digit index wraps to 0.

## Operation
- Prescaler cnt counts 0..DIV-1, wraps to 0; tick = (cnt == DIV-1). DIV=1: tick every cycle.
- Digit index idx advances on tick, 0..NUM_DIGITS-1, wraps to 0; wrap edge = commit point.
- Pending regs: load=1 captures value, dp_in, blank_in, sets pend_valid. Repeat load before commit overwrites pending (last wins).
- Commit: on wrap edge, if pend_valid, pending copied to display regs, pend_valid cleared. Load on same edge as wrap: the incoming inputs commit directly on that edge, pend_valid ends 0.
- Display is tear-free: a frame (idx 0..N-1) always shows one consistent loaded value.
- Decode (logical, lit=1): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Output stage: for current idx, if display blank[idx] (or suppressed, see Configuration) then seg/dp off and an all inactive; else seg = decode(digit idx), dp = dp[idx], an one-hot at idx. Polarity inversion applied last.
- Reset values: cnt=0, idx=0, pend_valid=0, display value=0, display dp=0, display blank=all 1. Outputs: seg all off (7'h7F when SEG_ACTIVE_LOW=1), dp off, an all inactive, frame_done=0.
- Reset mid-frame or with load pending: pending discarded, display returns to all-blank, scan restarts at idx 0.

## Timing
- seg/dp/an/frame_done are registered: reflect idx one cycle after idx changes.
- Each digit enabled for exactly DIV cycles; frame period NUM_DIGITS*DIV cycles.
- Load-to-visible latency: up to NUM_DIGITS*DIV cycles (wait for wrap) +1 output register cycle.
- frame_done high exactly one cycle, aligned with first output cycle of digit 0 of a frame.
- No glitch between digits: an and seg switch on the same edge.

## Configuration
- LED7SEG_LZS_EN defined: leading-zero suppression. Digits above the most significant nonzero digit are treated as blanked (an inactive). Digit 0 never suppressed; value 0 shows single "0". Explicit blank_in still applies; dp of a suppressed digit not shown.
- Undefined: all non-blanked digits displayed, leading zeros shown as "0".

## Test plan
- Reset: rst_n low mid-scan -> seg=7'h7F, dp=1, an=4'hF immediately (async), idx restarts at 0 after release.
- NUM_DIGITS=4, DIV=4: load value=16'h12AF, blank_in=0, dp_in=4'b0100 -> after next wrap, an cycles E,D,B,7 each 4 cycles with seg = ~71, ~77, ~5B|dp lit on digit 2, ~06; frame_done every 16 cycles.
- Tear-free: load 16'h1111 at idx=2, load 16'h2222 before wrap -> current frame unchanged, next frame all digits show "2" (~5B).
- Load coincident with wrap edge -> that frame shows the new value; no extra frame delay; pend_valid=0 after.
- blank_in=4'b1010 with value 16'h8888 -> an never active for digits 1,3; digits 0,2 show ~7F.
- LED7SEG_LZS_EN defined, value 16'h0050 -> digits 3,2 dark, digit 1 "5", digit 0 "0"; value 16'h0000 -> only digit 0 shows "0". Undefined -> all four digits shown.
